// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state, grant encoding and the
// width helper for the fetch-starvation counter.
// No ports; imported by mem_port_arbiter and mem_arb_select.

package mem_arb_pkg;

  // Transaction sequencer states. WAIT spans the memory read latency.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Which client owns the memory port for the current transaction.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_LOAD  = 2'd2,
    GNT_STORE = 2'd3
  } grant_t;

  // Bits needed to hold 0..starve_max inclusive.
  function automatic int starve_cnt_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection for the memory-port arbiter.
// Ports: i_fetch_vld/i_ld_vld/i_st_vld request strobes, i_starve_cnt current
//   fetch-starvation count, i_state sequencer state; o_grant is the winner.
// A winner is only produced while the port can take a new transaction
// (IDLE, or RESP for back-to-back service). Fixed priority store > load >
// fetch, except that a fetch which has waited out STARVE_MAX data grants wins.

module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SC_W       = starve_cnt_w(STARVE_MAX)
) (
  input  logic            i_fetch_vld,
  input  logic            i_ld_vld,
  input  logic            i_st_vld,
  input  logic [SC_W-1:0] i_starve_cnt,
  input  state_t          i_state,
  output grant_t          o_grant
);

  logic w_open;
  logic w_starved;

  assign w_open    = (i_state == IDLE) || (i_state == RESP);
  assign w_starved = i_fetch_vld && (i_starve_cnt == SC_W'(STARVE_MAX));

  always_comb begin
    o_grant = GNT_NONE;
    if (w_open) begin
      if (w_starved) begin
        o_grant = GNT_FETCH;
      end else if (i_st_vld) begin
        o_grant = GNT_STORE;
      end else if (i_ld_vld) begin
        o_grant = GNT_LOAD;
      end else if (i_fetch_vld) begin
        o_grant = GNT_FETCH;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch, data load and
// data store. One transaction in flight at a time: accept (cycle A), ISSUE
// (A+1, mem_en pulse), WAIT (MEM_LAT cycles), RESP (A+2+MEM_LAT, response
// strobe to the granted client; a new accept may happen in this cycle).
// Ports:
//   CLK, RESET          clock and asynchronous active-low reset
//   fetch_*             fetch request (valid/ready/addr) and response (rvalid/rdata)
//   ld_*                data-load request and response, same shape as fetch_*
//   st_*                store request (valid/ready/addr/data) and st_ack strobe
//   mem_*               memory strobe, write enable, address, write/read data
//   busy                transaction in flight

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,

  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,

  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,

  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ack,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  localparam int SC_W  = starve_cnt_w(STARVE_MAX);
  // MEM_LAT is at most 4, so the WAIT down-counter never exceeds 3.
  localparam int LAT_W = 3;

  state_t              r_state;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [SC_W-1:0]     r_starve_cnt;
  grant_t              r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic                r_fetch_rvalid;
  logic                r_ld_rvalid;
  logic                r_st_ack;
  logic [DATA_W-1:0]   r_fetch_rdata;
  logic [DATA_W-1:0]   r_ld_rdata;

  grant_t              w_grant;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [SC_W-1:0]     w_starve_nxt;

  mem_arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .SC_W       (SC_W)
  ) u_select (
    .i_fetch_vld  (fetch_valid),
    .i_ld_vld     (ld_valid),
    .i_st_vld     (st_valid),
    .i_starve_cnt (r_starve_cnt),
    .i_state      (r_state),
    .o_grant      (w_grant)
  );

  // Ready is held low while RESET is asserted so the handshake is quiet
  // even if a requester keeps valid high through reset.
  assign fetch_ready = RESET && (w_grant == GNT_FETCH);
  assign ld_ready    = RESET && (w_grant == GNT_LOAD);
  assign st_ready    = RESET && (w_grant == GNT_STORE);
  assign w_accept    = (w_grant != GNT_NONE);

  always_comb begin
    w_sel_addr = '0;
    case (w_grant)
      GNT_FETCH: w_sel_addr = fetch_addr;
      GNT_LOAD:  w_sel_addr = ld_addr;
      GNT_STORE: w_sel_addr = st_addr;
      default:   w_sel_addr = '0;
    endcase
  end

  // Starvation count seen by the next arbitration. Only a data grant while
  // fetch is waiting moves it up; anything else means fetch is not being
  // held off, so it restarts from zero.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if ((w_grant == GNT_FETCH) || !fetch_valid) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt != SC_W'(STARVE_MAX)) begin
      w_starve_nxt = r_starve_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state        <= IDLE;
      r_lat_cnt      <= '0;
      r_starve_cnt   <= '0;
      r_grant        <= GNT_NONE;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_we           <= 1'b0;
      r_fetch_rvalid <= 1'b0;
      r_ld_rvalid    <= 1'b0;
      r_st_ack       <= 1'b0;
      r_fetch_rdata  <= '0;
      r_ld_rdata     <= '0;
    end else begin
      // Response strobes are single-cycle pulses.
      r_fetch_rvalid <= 1'b0;
      r_ld_rvalid    <= 1'b0;
      r_st_ack       <= 1'b0;

      // Accepts only occur in IDLE or RESP (gated inside the selector).
      if (w_accept) begin
        r_grant      <= w_grant;
        r_addr       <= w_sel_addr;
        r_we         <= (w_grant == GNT_STORE);
        r_wdata      <= (w_grant == GNT_STORE) ? st_data : '0;
        r_starve_cnt <= w_starve_nxt;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_state   <= WAIT;
          r_lat_cnt <= LAT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          // Last WAIT cycle is the one where mem_rdata is valid.
          if (r_lat_cnt == '0) begin
            r_state <= RESP;
            case (r_grant)
              GNT_FETCH: begin
                r_fetch_rdata  <= mem_rdata;
                r_fetch_rvalid <= 1'b1;
              end
              GNT_LOAD: begin
                r_ld_rdata  <= mem_rdata;
                r_ld_rvalid <= 1'b1;
              end
              GNT_STORE: r_st_ack <= 1'b1;
              default: ;
            endcase
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          r_state <= w_accept ? ISSUE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en       = (r_state == ISSUE);
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign busy         = (r_state != IDLE);

  assign fetch_rvalid = r_fetch_rvalid;
  assign fetch_rdata  = r_fetch_rdata;
  assign ld_rvalid    = r_ld_rvalid;
  assign ld_rdata     = r_ld_rdata;
  assign st_ack       = r_st_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int SMAX  = 4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic rst_a, rst_b;

  // DUT A (MEM_LAT=1)
  logic f_vld, f_rdy, f_rv, l_vld, l_rdy, l_rv, s_vld, s_rdy, s_ack;
  logic [31:0] f_addr, f_rd, l_addr, l_rd, s_addr, s_dat;
  logic m_en, m_we, bsy;
  logic [31:0] m_addr, m_wd, m_rd;
  // DUT B (MEM_LAT=3)
  logic bf_vld, bf_rdy, bf_rv, bl_vld, bl_rdy, bl_rv, bs_vld, bs_rdy, bs_ack;
  logic [31:0] bf_addr, bf_rd, bl_addr, bl_rd, bs_addr, bs_dat;
  logic bm_en, bm_we, b_bsy;
  logic [31:0] bm_addr, bm_wd, bm_rd;

  logic [136:0] outs_a, outs_b;
  assign outs_a = {f_rdy, f_rv, f_rd, l_rdy, l_rv, l_rd, s_rdy, s_ack,
                   m_en, m_we, m_addr, m_wd, bsy};
  assign outs_b = {bf_rdy, bf_rv, bf_rd, bl_rdy, bl_rv, bl_rd, bs_rdy, bs_ack,
                   bm_en, bm_we, bm_addr, bm_wd, b_bsy};

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A), .STARVE_MAX(SMAX)) u_dut (
    .CLK(CLK), .RESET(rst_a),
    .fetch_valid(f_vld), .fetch_ready(f_rdy), .fetch_addr(f_addr),
    .fetch_rvalid(f_rv), .fetch_rdata(f_rd),
    .ld_valid(l_vld), .ld_ready(l_rdy), .ld_addr(l_addr),
    .ld_rvalid(l_rv), .ld_rdata(l_rd),
    .st_valid(s_vld), .st_ready(s_rdy), .st_addr(s_addr), .st_data(s_dat), .st_ack(s_ack),
    .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wd), .mem_rdata(m_rd),
    .busy(bsy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B), .STARVE_MAX(SMAX)) u_dut_b (
    .CLK(CLK), .RESET(rst_b),
    .fetch_valid(bf_vld), .fetch_ready(bf_rdy), .fetch_addr(bf_addr),
    .fetch_rvalid(bf_rv), .fetch_rdata(bf_rd),
    .ld_valid(bl_vld), .ld_ready(bl_rdy), .ld_addr(bl_addr),
    .ld_rvalid(bl_rv), .ld_rdata(bl_rd),
    .st_valid(bs_vld), .st_ready(bs_rdy), .st_addr(bs_addr), .st_data(bs_dat), .st_ack(bs_ack),
    .mem_en(bm_en), .mem_we(bm_we), .mem_addr(bm_addr), .mem_wdata(bm_wd), .mem_rdata(bm_rd),
    .busy(b_bsy)
  );

  // Behavioural memories: data appears MEM_LAT cycles after the mem_en cycle,
  // random junk on mem_rdata at every other time.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe_a [LAT_A];
  logic [31:0] pipe_b [LAT_B];

  always @(posedge CLK) begin
    if (m_en && m_we) mem_a[m_addr[9:2]] = m_wd;
    for (int i = LAT_A - 1; i > 0; i--) pipe_a[i] <= pipe_a[i-1];
    pipe_a[0] <= (m_en && !m_we) ? mem_a[m_addr[9:2]] : $urandom;
  end
  assign m_rd = pipe_a[LAT_A-1];

  always @(posedge CLK) begin
    if (bm_en && bm_we) mem_b[bm_addr[9:2]] = bm_wd;
    for (int i = LAT_B - 1; i > 0; i--) pipe_b[i] <= pipe_b[i-1];
    pipe_b[0] <= (bm_en && !bm_we) ? mem_b[bm_addr[9:2]] : $urandom;
  end
  assign bm_rd = pipe_b[LAT_B-1];

  // Requesters must hold valid and payload until accepted.
  logic [2:0]  pend;
  logic [31:0] pf, pl, ps, psd;
  always @(posedge CLK) begin
    if (!rst_a) begin
      pend <= 3'b000;
    end else begin
      if (pend[0]) assert (f_vld && f_addr == pf) else $error("protocol: fetch request changed before accept");
      if (pend[1]) assert (l_vld && l_addr == pl) else $error("protocol: load request changed before accept");
      if (pend[2]) assert (s_vld && s_addr == ps && s_dat == psd) else $error("protocol: store request changed before accept");
      pend <= {s_vld && !s_rdy, l_vld && !l_rdy, f_vld && !f_rdy};
      pf   <= f_addr;
      pl   <= l_addr;
      ps   <= s_addr;
      psd  <= s_dat;
    end
  end

  task automatic clear_inputs;
    f_vld = 0; f_addr = 0; l_vld = 0; l_addr = 0; s_vld = 0; s_addr = 0; s_dat = 0;
    bf_vld = 0; bf_addr = 0; bl_vld = 0; bl_addr = 0; bs_vld = 0; bs_addr = 0; bs_dat = 0;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while ((bsy !== 1'b0 || f_rv || l_rv || s_ack) && n < 30) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (bsy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, bsy, n);
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_a = 0; rst_b = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (outs_a !== '0) begin bad++; $display("FAIL reset_held_a: outs=%h want 0", outs_a); end
    total++;
    if (outs_b !== '0) begin bad++; $display("FAIL reset_held_b: outs=%h want 0", outs_b); end
    rst_a = 1; rst_b = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      total++;
      if (outs_a !== '0) begin bad++; $display("FAIL reset_idle_a[%0d]: outs=%h want 0", i, outs_a); end
    end
  endtask

  task automatic test_single_load;
    @(posedge CLK); #1;
    l_vld = 1; l_addr = 32'h100;
    @(negedge CLK);
    total++;
    if (l_rdy !== 1'b1) begin bad++; $display("FAIL sl_ready: got %b want 1", l_rdy); end
    @(posedge CLK); #1;
    l_vld = 0; l_addr = 0;
    @(negedge CLK); // A+1
    total++;
    if ({m_en, m_we, m_addr, m_wd, l_rv} !== {1'b1, 1'b0, 32'h100, 32'h0, 1'b0}) begin
      bad++; $display("FAIL sl_issue: en=%b we=%b addr=%h wd=%h rv=%b want 1 0 100 0 0", m_en, m_we, m_addr, m_wd, l_rv);
    end
    @(negedge CLK); // A+2
    total++;
    if ({m_en, l_rv} !== 2'b00) begin bad++; $display("FAIL sl_wait: en=%b rv=%b want 0 0", m_en, l_rv); end
    @(negedge CLK); // A+3
    total++;
    if ({l_rv, l_rd} !== {1'b1, 32'hDEADBEEF}) begin
      bad++; $display("FAIL sl_resp: rv=%b rdata=%h want 1 deadbeef", l_rv, l_rd);
    end
    @(negedge CLK); // A+4
    total++;
    if ({l_rv, bsy, l_rd} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
      bad++; $display("FAIL sl_after: rv=%b busy=%b rdata=%h want 0 0 deadbeef", l_rv, bsy, l_rd);
    end
  endtask

  task automatic test_store_load;
    int n;
    @(posedge CLK); #1;
    s_vld = 1; s_addr = 32'h40; s_dat = 32'h12345678;
    @(negedge CLK);
    total++;
    if (s_rdy !== 1'b1) begin bad++; $display("FAIL st_ready: got %b want 1", s_rdy); end
    @(posedge CLK); #1;
    s_vld = 0; s_addr = 0; s_dat = 0;
    @(negedge CLK); // A+1
    total++;
    if ({m_en, m_we, m_addr, m_wd} !== {1'b1, 1'b1, 32'h40, 32'h12345678}) begin
      bad++; $display("FAIL st_issue: en=%b we=%b addr=%h wd=%h want 1 1 40 12345678", m_en, m_we, m_addr, m_wd);
    end
    @(negedge CLK); // A+2
    total++;
    if (s_ack !== 1'b0) begin bad++; $display("FAIL st_early_ack: got %b want 0", s_ack); end
    @(negedge CLK); // A+3
    total++;
    if (s_ack !== 1'b1) begin bad++; $display("FAIL st_ack: got %b want 1", s_ack); end
    @(posedge CLK); #1;
    l_vld = 1; l_addr = 32'h40;
    @(negedge CLK);
    @(posedge CLK); #1;
    l_vld = 0;
    n = 0;
    while (l_rv !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    total++;
    if ({l_rv, l_rd} !== {1'b1, 32'h12345678} || n != 3) begin
      bad++; $display("FAIL st_readback: rv=%b rdata=%h after %0d cycles want 1 12345678 after 3", l_rv, l_rd, n);
    end
    wait_idle_a("st");
  endtask

  task automatic test_all_three;
    int as, al, af, n;
    as = -1; al = -1; af = -1; n = 0;
    @(posedge CLK); #1;
    f_vld = 1; f_addr = 32'h10; l_vld = 1; l_addr = 32'h14;
    s_vld = 1; s_addr = 32'h18; s_dat = 32'hA1B2C3D4;
    while ((f_vld || l_vld || s_vld) && n < 20) begin
      logic fa, la, sa;
      @(negedge CLK);
      fa = f_vld && f_rdy; la = l_vld && l_rdy; sa = s_vld && s_rdy;
      if (32'(fa) + 32'(la) + 32'(sa) > 1) begin
        total++; bad++; $display("FAIL a3_onehot: ready f=%b l=%b s=%b want at most one", f_rdy, l_rdy, s_rdy);
      end
      if (fa) af = cyc;
      if (la) al = cyc;
      if (sa) as = cyc;
      @(posedge CLK); #1;
      if (fa) f_vld = 0;
      if (la) l_vld = 0;
      if (sa) s_vld = 0;
      n++;
    end
    total++;
    if (as < 0 || al - as != 3) begin bad++; $display("FAIL a3_store_then_load: store@%0d load@%0d want gap 3", as, al); end
    total++;
    if (al < 0 || af - al != 3) begin bad++; $display("FAIL a3_load_then_fetch: load@%0d fetch@%0d want gap 3", al, af); end
    f_vld = 0; l_vld = 0; s_vld = 0;
    wait_idle_a("a3");
  endtask

  task automatic test_starvation;
    int fetches, run, n;
    int runs [2];
    fetches = 0; run = 0; n = 0; runs[0] = -1; runs[1] = -1;
    @(posedge CLK); #1;
    f_vld = 1; f_addr = 32'h300; s_vld = 1; s_addr = 32'h340; s_dat = $urandom;
    while ((f_vld || s_vld) && n < 80) begin
      logic fa, sa;
      @(negedge CLK);
      fa = f_vld && f_rdy; sa = s_vld && s_rdy;
      if (fa) begin runs[fetches] = run; fetches++; run = 0; end
      if (sa) run++;
      @(posedge CLK); #1;
      if (fa) begin
        if (fetches < 2) f_addr = f_addr + 4; else f_vld = 0;
      end
      if (sa) begin
        if (fetches >= 2) s_vld = 0;
        else begin s_addr = s_addr + 4; s_dat = $urandom; end
      end
      n++;
    end
    total++;
    if (runs[0] !== 4) begin bad++; $display("FAIL starve_first: %0d store accepts before fetch, want 4", runs[0]); end
    total++;
    if (runs[1] !== 4) begin bad++; $display("FAIL starve_second: %0d store accepts before fetch, want 4", runs[1]); end
    f_vld = 0; s_vld = 0;
    wait_idle_a("starve");
  endtask

  task automatic apply_reset_a;
    @(posedge CLK); #1;
    f_vld = 0; l_vld = 0; s_vld = 0;
    @(negedge CLK); rst_a = 0;
    repeat (2) @(negedge CLK);
    rst_a = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h200 | ($urandom_range(0, 15) << 2);
  endfunction

  // Reference: the port is free at a cycle at or after free_at; the winner is
  // chosen by priority from the valids present; the response lands
  // MEM_LAT+2 cycles after the accept with the data memory held at that time.
  task automatic test_random;
    int free_at, last_acc, starve, exp_cyc, w, exp_cl, c;
    logic [31:0] exp_data, e_addr, e_wd;
    logic e_we, fa, la, sa, drain;
    logic [2:0] exp_rdy, exp_rsp;
    apply_reset_a();
    free_at = 0; last_acc = -100; starve = 0; exp_cyc = -1; exp_cl = 0;
    exp_data = 0; e_addr = 0; e_wd = 0; e_we = 0;
    for (int it = 0; it < 420; it++) begin
      drain = (it >= 360);
      @(negedge CLK);
      c = cyc;
      w = 0;
      if (c >= free_at) begin
        if (f_vld && starve == SMAX) w = 1;
        else if (s_vld) w = 3;
        else if (l_vld) w = 2;
        else if (f_vld) w = 1;
      end
      exp_rdy = {w == 3, w == 2, w == 1};
      total++;
      if ({s_rdy, l_rdy, f_rdy} !== exp_rdy) begin
        bad++; $display("FAIL rnd_ready@%0d: s/l/f=%b want %b", c, {s_rdy, l_rdy, f_rdy}, exp_rdy);
      end
      exp_rsp = (c == exp_cyc) ? {exp_cl == 3, exp_cl == 2, exp_cl == 1} : 3'b000;
      total++;
      if ({s_ack, l_rv, f_rv} !== exp_rsp) begin
        bad++; $display("FAIL rnd_resp@%0d: ack/lrv/frv=%b want %b", c, {s_ack, l_rv, f_rv}, exp_rsp);
      end
      if (c == exp_cyc && exp_cl == 2) begin
        total++;
        if (l_rd !== exp_data) begin bad++; $display("FAIL rnd_ld_data@%0d: got %h want %h", c, l_rd, exp_data); end
      end
      if (c == exp_cyc && exp_cl == 1) begin
        total++;
        if (f_rd !== exp_data) begin bad++; $display("FAIL rnd_f_data@%0d: got %h want %h", c, f_rd, exp_data); end
      end
      total++;
      if ({m_en, bsy} !== {c == last_acc + 1, c > last_acc && c <= last_acc + LAT_A + 2}) begin
        bad++; $display("FAIL rnd_en_busy@%0d: en=%b busy=%b last_accept=%0d", c, m_en, bsy, last_acc);
      end
      if (c == last_acc + 1) begin
        total++;
        if ({m_we, m_addr, m_wd} !== {e_we, e_addr, e_wd}) begin
          bad++; $display("FAIL rnd_issue@%0d: we=%b addr=%h wd=%h want %b %h %h", c, m_we, m_addr, m_wd, e_we, e_addr, e_wd);
        end
      end
      if (w != 0) begin
        if (w == 1 || !f_vld) starve = 0;
        else if (starve < SMAX) starve++;
        e_we = (w == 3);
        e_addr = (w == 3) ? s_addr : (w == 2) ? l_addr : f_addr;
        e_wd = (w == 3) ? s_dat : 32'h0;
        if (w == 3) ref_mem[s_addr[9:2]] = s_dat;
        else exp_data = ref_mem[e_addr[9:2]];
        exp_cl = w; last_acc = c; exp_cyc = c + LAT_A + 2; free_at = exp_cyc;
      end
      fa = f_vld && f_rdy; la = l_vld && l_rdy; sa = s_vld && s_rdy;
      @(posedge CLK); #1;
      if (fa) f_vld = 0;
      if (la) l_vld = 0;
      if (sa) s_vld = 0;
      if (!drain) begin
        if (!f_vld && $urandom_range(0, 9) < 7) begin f_vld = 1; f_addr = rand_addr(); end
        if (!l_vld && $urandom_range(0, 9) < 5) begin l_vld = 1; l_addr = rand_addr(); end
        if (!s_vld && $urandom_range(0, 9) < 6) begin s_vld = 1; s_addr = rand_addr(); s_dat = $urandom; end
      end
    end
    total++;
    if (f_vld || l_vld || s_vld || bsy !== 1'b0) begin
      bad++; $display("FAIL rnd_drain: valids f/l/s=%b%b%b busy=%b want all 0", f_vld, l_vld, s_vld, bsy);
    end
  endtask

  task automatic test_reset_in_wait;
    @(posedge CLK); #1;
    bl_vld = 1; bl_addr = 32'h80;
    @(negedge CLK);
    total++;
    if (bl_rdy !== 1'b1) begin bad++; $display("FAIL rw_ready: got %b want 1", bl_rdy); end
    @(posedge CLK); #1;
    bl_vld = 0;
    @(negedge CLK); // A+1
    total++;
    if (bm_en !== 1'b1) begin bad++; $display("FAIL rw_issue: mem_en=%b want 1", bm_en); end
    @(posedge CLK); #1; // A+2, inside WAIT
    total++;
    if (b_bsy !== 1'b1) begin bad++; $display("FAIL rw_busy: got %b want 1", b_bsy); end
    rst_b = 0;
    #1;
    total++;
    if (outs_b !== '0) begin bad++; $display("FAIL rw_reset_outs: outs=%h want 0", outs_b); end
    repeat (2) @(negedge CLK);
    rst_b = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      total++;
      if ({bf_rv, bl_rv, bs_ack, bm_en, b_bsy} !== 5'b0) begin
        bad++; $display("FAIL rw_dropped[%0d]: frv=%b lrv=%b ack=%b en=%b busy=%b want all 0", i, bf_rv, bl_rv, bs_ack, bm_en, b_bsy);
      end
    end
    @(posedge CLK); #1;
    bl_vld = 1; bl_addr = 32'h84;
    @(negedge CLK);
    total++;
    if (bl_rdy !== 1'b1) begin bad++; $display("FAIL rw_ready2: got %b want 1", bl_rdy); end
    @(posedge CLK); #1;
    bl_vld = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      total++;
      if (bl_rv !== 1'(k == 5)) begin bad++; $display("FAIL rw_rvalid@A+%0d: got %b want %b", k, bl_rv, k == 5); end
      if (k == 5) begin
        total++;
        if (bl_rd !== 32'h0BADCAFE) begin bad++; $display("FAIL rw_rdata: got %h want 0badcafe", bl_rd); end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i]   = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
      mem_b[i]   = 32'hB600_0000 | i;
    end
    mem_a[8'h40] = 32'hDEADBEEF;
    mem_b[8'h21] = 32'h0BADCAFE;
    test_reset();
    test_single_load();
    test_store_load();
    test_all_three();
    test_starvation();
    test_random();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
